// File: rtl/mem_pkg.sv
// Shared types and default sizing for the memory responder.
package mem_pkg;

  localparam int unsigned DefAddrWidth  = 9;
  localparam int unsigned DefDataWidth  = 32;
  localparam int unsigned DefDepth      = 512;
  localparam int unsigned DefWaitStates = 1;
  localparam int unsigned CntWidth      = 4;

  typedef enum logic [1:0] {
    StIdle,
    StAccess,
    StResp
  } state_e;

  typedef enum logic {
    OP_RD,
    OP_WR
  } op_e;

endpackage

// File: rtl/ram_sp.sv
// Synchronous single-port RAM with registered read data.
// Out-of-range addresses read 0 and ignore writes; i_clr zeroes only the output register.
module ram_sp #(
  parameter int unsigned ADDR_WIDTH = 9,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned DEPTH      = 512
) (
  input  logic                  clock,
  input  logic                  i_clr,
  input  logic                  i_we,
  input  logic                  i_re,
  input  logic [ADDR_WIDTH-1:0] i_addr,
  input  logic [DATA_WIDTH-1:0] i_din,
  output logic [DATA_WIDTH-1:0] o_dout
);

  localparam int unsigned IdxWidth = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [DATA_WIDTH-1:0] r_mem [DEPTH];
  logic [DATA_WIDTH-1:0] r_dout;
  logic [IdxWidth-1:0]   w_idx;
  logic                  w_in_range;

  assign w_in_range = (32'(i_addr) < DEPTH);
  assign w_idx      = i_addr[IdxWidth-1:0];

  always_ff @(posedge clock) begin
    if (i_we && w_in_range) begin
      r_mem[w_idx] <= i_din;
    end
  end

  always_ff @(posedge clock) begin
    if (i_clr) begin
      r_dout <= '0;
    end else if (i_re) begin
      r_dout <= w_in_range ? r_mem[w_idx] : '0;
    end
  end

  assign o_dout = r_dout;

endmodule

// File: rtl/mem_responder.sv
// Memory-side responder: 4-phase Read/Write handshake with programmable wait states.
// Optional MEM_ERR_EN adds an err output for conflicting or out-of-range requests.
module mem_responder
  import mem_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH  = DefAddrWidth,
  parameter int unsigned DATA_WIDTH  = DefDataWidth,
  parameter int unsigned DEPTH       = DefDepth,
  parameter int unsigned WAIT_STATES = DefWaitStates
) (
  input  logic                  clock,
  input  logic                  clear,
  input  logic                  Read,
  input  logic                  Write,
  input  logic [ADDR_WIDTH-1:0] address,
  input  logic [DATA_WIDTH-1:0] data_in,
  output logic [DATA_WIDTH-1:0] Mdatain,
  output logic                  Done,
  output logic                  Busy
`ifdef MEM_ERR_EN
  ,
  output logic                  err
`endif
);

  state_e                r_state, w_state_d;
  logic [CntWidth-1:0]   r_cnt, w_cnt_d;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [DATA_WIDTH-1:0] r_data;
  op_e                   r_op;
  logic                  w_capture;
  logic                  w_fire;
  logic                  w_we;
  logic                  w_re;

  always_comb begin
    w_state_d = r_state;
    w_cnt_d   = r_cnt;
    w_capture = 1'b0;
    w_fire    = 1'b0;
    unique case (r_state)
      StIdle: begin
        if (Read || Write) begin
          w_capture = 1'b1;
          w_cnt_d   = CntWidth'(WAIT_STATES);
          w_state_d = StAccess;
        end
      end
      StAccess: begin
        if (r_cnt != '0) begin
          w_cnt_d = r_cnt - 1'b1;
        end else begin
          w_fire    = 1'b1;
          w_state_d = StResp;
        end
      end
      StResp: begin
        if (!(Read || Write)) begin
          w_state_d = StIdle;
        end
      end
      default: w_state_d = StIdle;
    endcase
  end

  always_ff @(posedge clock) begin
    if (clear) begin
      r_state <= StIdle;
      r_cnt   <= '0;
      r_addr  <= '0;
      r_data  <= '0;
      r_op    <= OP_RD;
    end else begin
      r_state <= w_state_d;
      r_cnt   <= w_cnt_d;
      if (w_capture) begin
        r_addr <= address;
        r_data <= data_in;
        r_op   <= Read ? OP_RD : OP_WR;
      end
    end
  end

`ifdef MEM_ERR_EN
  logic r_both;
  logic r_err;
  logic w_in_range;

  assign w_in_range = (32'(r_addr) < DEPTH);

  always_ff @(posedge clock) begin
    if (clear) begin
      r_both <= 1'b0;
      r_err  <= 1'b0;
    end else begin
      if (w_capture) begin
        r_both <= Read && Write;
      end
      if (w_fire) begin
        r_err <= r_both || !w_in_range;
      end else if (r_state == StResp && w_state_d == StIdle) begin
        r_err <= 1'b0;
      end
    end
  end

  assign err  = r_err;
  // Out-of-range reads keep the previous Mdatain instead of returning zero.
  assign w_re = w_fire && (r_op == OP_RD) && w_in_range && !clear;
`else
  assign w_re = w_fire && (r_op == OP_RD) && !clear;
`endif

  assign w_we = w_fire && (r_op == OP_WR) && !clear;

  ram_sp #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (DEPTH)
  ) u_ram (
    .clock  (clock),
    .i_clr  (clear),
    .i_we   (w_we),
    .i_re   (w_re),
    .i_addr (r_addr),
    .i_din  (r_data),
    .o_dout (Mdatain)
  );

  assign Busy = (r_state != StIdle);
  assign Done = (r_state == StResp);

endmodule

// File: tb/tb_mem_responder.sv
// Directed bench for mem_responder: three instances cover WAIT_STATES 1, 0 and 3 (DEPTH 256).
module tb_mem_responder;

  logic        clock = 1'b0;
  logic        clear;
  logic        rd [3];
  logic        wr [3];
  logic [8:0]  ad [3];
  logic [31:0] di [3];
  logic [31:0] mo [3];
  logic        dn [3];
  logic        bz [3];
`ifdef MEM_ERR_EN
  logic        er [3];
`endif

  int n_checks = 0;
  int n_err    = 0;

  always #5 clock = ~clock;

  mem_responder #(.ADDR_WIDTH(9), .DATA_WIDTH(32), .DEPTH(512), .WAIT_STATES(1)) u_dut_w1 (
    .clock(clock), .clear(clear), .Read(rd[0]), .Write(wr[0]), .address(ad[0]),
    .data_in(di[0]), .Mdatain(mo[0]), .Done(dn[0]), .Busy(bz[0])
`ifdef MEM_ERR_EN
    , .err(er[0])
`endif
  );

  mem_responder #(.ADDR_WIDTH(9), .DATA_WIDTH(32), .DEPTH(512), .WAIT_STATES(0)) u_dut_w0 (
    .clock(clock), .clear(clear), .Read(rd[1]), .Write(wr[1]), .address(ad[1]),
    .data_in(di[1]), .Mdatain(mo[1]), .Done(dn[1]), .Busy(bz[1])
`ifdef MEM_ERR_EN
    , .err(er[1])
`endif
  );

  mem_responder #(.ADDR_WIDTH(9), .DATA_WIDTH(32), .DEPTH(256), .WAIT_STATES(3)) u_dut_w3 (
    .clock(clock), .clear(clear), .Read(rd[2]), .Write(wr[2]), .address(ad[2]),
    .data_in(di[2]), .Mdatain(mo[2]), .Done(dn[2]), .Busy(bz[2])
`ifdef MEM_ERR_EN
    , .err(er[2])
`endif
  );

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Raise a request, scramble address/data once captured, and time Done.
  task automatic access(input int i, input logic r, input logic w, input logic [8:0] a,
                        input logic [31:0] d, input int exp_lat, input string tag);
    int lat;
    rd[i] = r;
    wr[i] = w;
    ad[i] = a;
    di[i] = d;
    tick();
    lat = 1;
    check({tag, "_busy"}, 32'(bz[i]), 32'd1);
    ad[i] = ~a;
    di[i] = ~d;
    while (lat < 20 && !dn[i]) begin
      tick();
      lat++;
    end
    check({tag, "_lat"}, 32'(lat), 32'(exp_lat));
  endtask

  task automatic release_req(input int i, input string tag);
    rd[i] = 1'b0;
    wr[i] = 1'b0;
    tick();
    check({tag, "_rel_done"}, 32'(dn[i]), 32'd0);
    check({tag, "_rel_busy"}, 32'(bz[i]), 32'd0);
  endtask

  initial begin
    logic [31:0] exp_oor;
    for (int i = 0; i < 3; i++) begin
      rd[i] = 1'b0;
      wr[i] = 1'b0;
      ad[i] = '0;
      di[i] = '0;
    end
    clear = 1'b1;
    tick();
    tick();
    clear = 1'b0;
    check("rst_mdatain", mo[0], 32'h0);
    check("rst_done", 32'(dn[0]), 32'd0);
    check("rst_busy", 32'(bz[0]), 32'd0);

    // WAIT_STATES=1: Done after edge N+2
    access(0, 1'b0, 1'b1, 9'h012, 32'h0000_0012, 3, "w1_wr12");
    check("w1_wr12_mdatain_kept", mo[0], 32'h0);
    release_req(0, "w1_wr12");
    access(0, 1'b1, 1'b0, 9'h012, 32'h0, 3, "w1_rd12");
    check("w1_rd12_data", mo[0], 32'h0000_0012);

    // Held request: Done stays, no re-access
    for (int k = 0; k < 5; k++) begin
      tick();
      check("hold_done", 32'(dn[0]), 32'd1);
    end
    check("hold_busy", 32'(bz[0]), 32'd1);
    release_req(0, "hold");
    access(0, 1'b1, 1'b0, 9'h012, 32'h0, 3, "reassert");
    release_req(0, "reassert");

    // Simultaneous Read&Write: read served, write dropped
    access(0, 1'b0, 1'b1, 9'h014, 32'h0000_0014, 3, "w1_wr14");
    release_req(0, "w1_wr14");
    access(0, 1'b1, 1'b1, 9'h014, 32'hDEAD_BEEF, 3, "rw14");
    check("rw14_data", mo[0], 32'h0000_0014);
`ifdef MEM_ERR_EN
    check("rw14_err", 32'(er[0]), 32'd1);
`endif
    release_req(0, "rw14");
    access(0, 1'b1, 1'b0, 9'h012, 32'h0, 3, "w1_rd12b");
    check("w1_rd12b_data", mo[0], 32'h0000_0012);
    release_req(0, "w1_rd12b");
    access(0, 1'b1, 1'b0, 9'h014, 32'h0, 3, "rd14_after_rw");
    check("rd14_after_rw_data", mo[0], 32'h0000_0014);
    release_req(0, "rd14_after_rw");

    // WAIT_STATES=0: Done after edge N+1
    access(1, 1'b0, 1'b1, 9'h030, 32'hCAFE_0001, 2, "w0_wr30");
    release_req(1, "w0_wr30");
    access(1, 1'b1, 1'b0, 9'h030, 32'h0, 2, "w0_rd30");
    check("w0_rd30_data", mo[1], 32'hCAFE_0001);
    release_req(1, "w0_rd30");

    // WAIT_STATES=3, DEPTH=256: out-of-range handling
    access(2, 1'b0, 1'b1, 9'h0FF, 32'h0000_0077, 5, "w3_wrff");
    release_req(2, "w3_wrff");
    access(2, 1'b0, 1'b1, 9'h1FF, 32'h0000_005A, 5, "w3_wr1ff");
    release_req(2, "w3_wr1ff");
    access(2, 1'b1, 1'b0, 9'h0FF, 32'h0, 5, "w3_rdff");
    check("w3_rdff_data", mo[2], 32'h0000_0077);
    release_req(2, "w3_rdff");
    access(2, 1'b1, 1'b0, 9'h1FF, 32'h0, 5, "w3_rd1ff");
`ifdef MEM_ERR_EN
    exp_oor = 32'h0000_0077;
    check("w3_rd1ff_err", 32'(er[2]), 32'd1);
`else
    exp_oor = 32'h0;
`endif
    check("w3_rd1ff_data", mo[2], exp_oor);
    release_req(2, "w3_rd1ff");

    // Clear on the edge that would commit a write aborts it
    access(0, 1'b0, 1'b1, 9'h018, 32'h1111_2222, 3, "w1_wr18");
    release_req(0, "w1_wr18");
    access(0, 1'b1, 1'b0, 9'h012, 32'h0, 3, "w1_rd12c");
    release_req(0, "w1_rd12c");
    wr[0] = 1'b1;
    ad[0] = 9'h018;
    di[0] = 32'hAAAA_5555;
    tick();
    tick();
    check("clr_pre_busy", 32'(bz[0]), 32'd1);
    clear = 1'b1;
    tick();
    check("clr_done", 32'(dn[0]), 32'd0);
    check("clr_busy", 32'(bz[0]), 32'd0);
    check("clr_mdatain", mo[0], 32'h0);
    clear = 1'b0;
    wr[0] = 1'b0;
    tick();
    access(0, 1'b1, 1'b0, 9'h018, 32'h0, 3, "rd18_after_clr");
    check("rd18_after_clr_data", mo[0], 32'h1111_2222);
    release_req(0, "rd18_after_clr");

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
